// File: rtl/fifo_stream_reader.sv
// Read-side master for a synchronous FIFO with 1-cycle read latency, re-presenting
// the words as a valid/ready stream through a 2-entry skid buffer.
module fifo_stream_reader #(
  parameter int WIDTH       = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  output logic                   o_fifo_ren,
  input  logic [WIDTH-1:0]       i_fifo_rdata,
  input  logic                   i_fifo_empty,
  input  logic                   i_enable,
  output logic                   o_valid,
  output logic [WIDTH-1:0]       o_data,
  input  logic                   i_ready,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic                   o_idle
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_e;

  occ_e                   state_q, state_d;
  logic                   inf_q, inf_d;
  logic [WIDTH-1:0]       head_q, head_d;
  logic [WIDTH-1:0]       tail_q, tail_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [1:0]             occ_s;
  logic [1:0]             level_s;
  logic                   pop_s;
  logic                   ren_s;

  // State register: occupancy, in-flight flag, buffer entries and delivery counter.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= EMPTY;
      inf_q   <= 1'b0;
      head_q  <= {WIDTH{1'b0}};
      tail_q  <= {WIDTH{1'b0}};
      count_q <= {COUNT_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      inf_q   <= inf_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Occupancy after this edge; ren may only fire while that stays below two.
  assign occ_s   = state_q;
  assign pop_s   = (state_q != EMPTY) && i_ready;
  assign level_s = occ_s + {1'b0, inf_q} - {1'b0, pop_s};
  assign ren_s   = i_rst && i_enable && !i_fifo_empty && (level_s < 2'd2);

  // Next-state: pop advances the head, an arriving word is appended behind it.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    inf_d   = ren_s;
    count_d = pop_s ? (count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1}) : count_q;
    case ({pop_s, inf_q})
      2'b01: begin
        if (state_q == EMPTY) begin
          head_d = i_fifo_rdata;
        end else begin
          tail_d = i_fifo_rdata;
        end
      end
      2'b10: begin
        if (state_q == TWO) begin
          head_d = tail_q;
        end else begin
          head_d = head_q;
        end
      end
      2'b11: begin
        if (state_q == TWO) begin
          head_d = tail_q;
          tail_d = i_fifo_rdata;
        end else begin
          head_d = i_fifo_rdata;
        end
      end
      default: begin
        head_d = head_q;
      end
    endcase
    case (level_s)
      2'd0:    state_d = EMPTY;
      2'd1:    state_d = ONE;
      default: state_d = TWO;
    endcase
  end

  // Outputs decoded from registered state; only ren is combinational.
  always_comb begin
    o_fifo_ren = ren_s;
    o_valid    = (state_q != EMPTY);
    o_data     = head_q;
    o_count    = count_q;
    o_idle     = (state_q == EMPTY) && !inf_q;
  end

  fifo_stream_reader_chk u_chk (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .inf_i  (inf_q),
    .occ_i  (occ_s),
    .pop_i  (pop_s)
  );

endmodule

// Checker: an arrival into a full buffer without a simultaneous pop would lose data.
module fifo_stream_reader_chk (
  input logic       i_clk,
  input logic       i_rst,
  input logic       inf_i,
  input logic [1:0] occ_i,
  input logic       pop_i
);

  // Overflow check sampled on every active edge outside reset.
  always @(posedge i_clk) begin
    if (i_rst) begin
      assert (!(inf_i && (occ_i == 2'd2) && !pop_i))
        else $error("buffer overflow: arrival with occ=2 and no pop");
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: behavioural 1-cycle-latency FIFO feeding fifo_stream_reader.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_ren;
  logic [7:0] fifo_rdata = 8'h00;
  logic       fifo_empty;
  logic       enable;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  logic [3:0] count;
  logic       idle;

  logic [7:0] mem [0:255];
  logic [7:0] dlv [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rcnt   = 0;
  int dcnt   = 0;
  int errors = 0;
  int checks = 0;
  int r0, d0, idx;

  fifo_stream_reader #(.WIDTH(8), .COUNT_WIDTH(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_fifo_ren   (fifo_ren),
    .i_fifo_rdata (fifo_rdata),
    .i_fifo_empty (fifo_empty),
    .i_enable     (enable),
    .o_valid      (valid),
    .o_data       (data),
    .i_ready      (ready),
    .o_count      (count),
    .o_idle       (idle)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  // FIFO read port model: registered data one cycle after an accepted read.
  always @(posedge clk) begin
    if (fifo_ren) begin
      fifo_rdata <= mem[rd_ptr[7:0]];
      rd_ptr     <= rd_ptr + 1;
      rcnt       <= rcnt + 1;
    end
  end

  // Log of every word handed over on the stream.
  always @(posedge clk) begin
    if (valid && ready) begin
      dlv[dcnt[7:0]] <= data;
      dcnt           <= dcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic push(input logic [7:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b0;
    enable = 1'b1;
    ready  = 1'b0;
    #2;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_idle",  {31'd0, idle},  32'd1);
    chk("rst_ren",   {31'd0, fifo_ren}, 32'd0);
    chk("rst_data",  {24'd0, data},  32'd0);
    cyc(1);
    rst = 1'b1;
    cyc(2);

    // Latency: ren in the cycle the FIFO goes non-empty, valid two cycles later.
    ready = 1'b1;
    push(8'h0A);
    #1;
    chk("lat_ren", {31'd0, fifo_ren}, 32'd1);
    cyc(1);
    chk("lat_valid_t1", {31'd0, valid}, 32'd0);
    chk("lat_idle_t1",  {31'd0, idle},  32'd0);
    cyc(1);
    chk("lat_valid_t2", {31'd0, valid}, 32'd1);
    chk("lat_data_t2",  {24'd0, data},  32'h0A);
    chk("lat_count_t2", {28'd0, count}, 32'd0);
    cyc(1);
    chk("lat_count_t3", {28'd0, count}, 32'd1);
    chk("lat_idle_t3",  {31'd0, idle},  32'd1);

    // Streaming: four words on four consecutive cycles.
    d0 = dcnt;
    for (int k = 1; k <= 4; k++) push(k[7:0]);
    #1;
    chk("str_ren", {31'd0, fifo_ren}, 32'd1);
    cyc(1);
    chk("str_valid_fill", {31'd0, valid}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      chk("str_valid", {31'd0, valid}, 32'd1);
      chk("str_data",  {24'd0, data},  k);
    end
    cyc(1);
    chk("str_valid_end", {31'd0, valid}, 32'd0);
    chk("str_idle",      {31'd0, idle},  32'd1);
    chk("str_count",     {28'd0, count}, 32'd5);
    chk("str_dcnt",      dcnt - d0,      32'd4);

    // Backpressure: only two reads while stalled, one more after a single pop.
    ready = 1'b0;
    r0 = rcnt;
    d0 = dcnt;
    for (int k = 1; k <= 4; k++) push(k[7:0]);
    cyc(5);
    chk("bp_reads2", rcnt - r0, 32'd2);
    chk("bp_valid",  {31'd0, valid}, 32'd1);
    chk("bp_data1",  {24'd0, data},  32'd1);
    chk("bp_ren_off", {31'd0, fifo_ren}, 32'd0);
    ready = 1'b1;
    #1;
    chk("bp_ren_pop", {31'd0, fifo_ren}, 32'd1);
    cyc(1);
    ready = 1'b0;
    #1;
    chk("bp_data2", {24'd0, data}, 32'd2);
    cyc(4);
    chk("bp_reads3",   rcnt - r0, 32'd3);
    chk("bp_data2_hold", {24'd0, data}, 32'd2);
    chk("bp_ren_off2", {31'd0, fifo_ren}, 32'd0);
    ready = 1'b1;
    cyc(6);
    chk("bp_dcnt", dcnt - d0, 32'd4);
    for (int k = 0; k < 4; k++) begin
      idx = d0 + k;
      chk("bp_order", {24'd0, dlv[idx[7:0]]}, k + 1);
    end
    chk("bp_count", {28'd0, count}, 32'd9);
    chk("bp_idle",  {31'd0, idle},  32'd1);

    // Enable gating: no reads while disabled; the in-flight word still arrives.
    enable = 1'b0;
    r0 = rcnt;
    d0 = dcnt;
    push(8'h21);
    push(8'h22);
    push(8'h23);
    cyc(4);
    chk("en_noreads", rcnt - r0, 32'd0);
    chk("en_valid",   {31'd0, valid}, 32'd0);
    chk("en_ren",     {31'd0, fifo_ren}, 32'd0);
    enable = 1'b1;
    #1;
    chk("en_ren_on", {31'd0, fifo_ren}, 32'd1);
    cyc(1);
    enable = 1'b0;
    #1;
    chk("en_ren_drop", {31'd0, fifo_ren}, 32'd0);
    cyc(5);
    chk("en_reads1", rcnt - r0, 32'd1);
    chk("en_dcnt1",  dcnt - d0, 32'd1);
    idx = d0;
    chk("en_word",   {24'd0, dlv[idx[7:0]]}, 32'h21);
    chk("en_idle",   {31'd0, idle}, 32'd1);
    wr_ptr = rd_ptr;
    enable = 1'b1;

    // Reset in the middle of streaming discards buffered and in-flight words.
    for (int k = 0; k < 8; k++) push(8'h31 + k[7:0]);
    cyc(3);
    rst = 1'b0;
    #1;
    chk("mrst_valid", {31'd0, valid}, 32'd0);
    chk("mrst_count", {28'd0, count}, 32'd0);
    chk("mrst_idle",  {31'd0, idle},  32'd1);
    chk("mrst_ren",   {31'd0, fifo_ren}, 32'd0);
    cyc(1);
    wr_ptr = rd_ptr;
    d0 = dcnt;
    rst = 1'b1;
    cyc(5);
    chk("mrst_after_valid", {31'd0, valid}, 32'd0);
    chk("mrst_after_dcnt",  dcnt - d0,      32'd0);

    // Counter wrap: 17 deliveries on a 4-bit counter leave it at 1.
    d0 = dcnt;
    for (int k = 0; k < 17; k++) push(8'h40 + k[7:0]);
    cyc(22);
    chk("wrap_count", {28'd0, count}, 32'd1);
    chk("wrap_dcnt",  dcnt - d0,      32'd17);
    idx = d0 + 16;
    chk("wrap_last",  {24'd0, dlv[idx[7:0]]}, 32'h50);
    chk("wrap_idle",  {31'd0, idle}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
